// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx
//   Philips I2S transmitter at the output of the FIR datapath. One sample is
//   accepted per audio frame through a valid/ready handshake into a one-entry
//   holding register. At each frame boundary the held sample moves to the
//   frame register. It is then sent MSB first, after a one-bit delay, in both
//   the left and the right slot.
//
// Build option
//   FIR_I2S_TX_HOLD_LAST_EN : when defined, a frame that starts with an empty
//   holding register repeats the previous sample. When undefined, that frame
//   is silent. The underrun pulse is raised in both builds.
//
// Parameters
//   DATA_W   : sample width, two's complement
//   SLOT_W   : bits per channel slot (>= DATA_W+1)
//   BCLK_DIV : clk cycles per BCLK period (even, >= 2)
//
// Ports
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   s_data    : sample from the filter
//   s_valid   : s_data valid
//   s_ready   : holding register empty
//   i2s_bclk  : bit clock (registered)
//   i2s_lrclk : word select, 0 = left, 1 = right (registered)
//   i2s_sd    : serial data (registered)
//   underrun  : one-cycle pulse at a frame start that found the hold empty

module fir_i2s_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sd,
  output logic              underrun
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_V   = BIT_W'(SLOT_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] frame_reg;

  logic              period_start;
  logic              boundary;
  logic [DIV_W-1:0]  div_nxt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BIT_W-1:0]  slot_pos;
  logic [DATA_W-1:0] frame_nxt;
  logic              sd_nxt;
  logic              bclk_nxt;
  logic              lrclk_nxt;

  assign s_ready = !hold_full;

  // The registered outputs are computed from the counter values that the
  // coming edge will load. This keeps SD, LRCLK and BCLK aligned with the bit
  // period they describe, without an extra pipeline stage.
  always_comb begin
    period_start = (div_cnt == DIV_LAST);
    boundary     = period_start && (bit_cnt == BIT_LAST);

    div_nxt = period_start ? '0 : div_cnt + DIV_W'(1);

    bit_nxt = bit_cnt;
    if (period_start) begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    end

    frame_nxt = frame_reg;
    if (boundary) begin
      if (hold_full) begin
        frame_nxt = hold;
      end else begin
`ifdef FIR_I2S_TX_HOLD_LAST_EN
        frame_nxt = frame_reg;
`else
        frame_nxt = '0;
`endif
      end
    end

    slot_pos = (bit_nxt >= SLOT_V) ? bit_nxt - SLOT_V : bit_nxt;

    // Slot bit p carries frame bit DATA_W-p for p = 1..DATA_W. The delay bit
    // (p = 0) and the trailing pad bits match no index here, so they send 0.
    sd_nxt = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (slot_pos == BIT_W'(DATA_W - i)) begin
        sd_nxt = frame_nxt[i];
      end
    end

    bclk_nxt  = (div_nxt >= DIV_HALF);
    lrclk_nxt = (bit_nxt >= SLOT_V);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      frame_reg <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sd    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      frame_reg <= frame_nxt;
      i2s_bclk  <= bclk_nxt;
      if (period_start) begin
        i2s_sd    <= sd_nxt;
        i2s_lrclk <= lrclk_nxt;
      end
      underrun <= boundary && !hold_full;

      // A boundary only drains a full hold. A transfer only fills an empty
      // hold. So a sample that arrives on a boundary with the hold empty is
      // still counted as an underrun, and it waits for the next frame.
      if (boundary && hold_full) begin
        hold_full <= 1'b0;
      end else if (s_valid && !hold_full) begin
        hold      <= s_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fir_i2s_tx.md
# fir_i2s_tx

I2S serial transmitter that drains the parallel 24-bit sample stream produced by the FIR filter and serializes it onto a standard Philips I2S link (BCLK, LRCLK, SD) for an external DAC. It sits at the output end of the filter datapath. It accepts one sample per audio frame through a valid/ready handshake, buffers it in a one-entry holding register, and transmits it on both the left and right channels.

## Interface
- `DATA_W`, 24: sample width in bits; two's complement.
- `SLOT_W`, 32: bits per channel slot; must be ≥ `DATA_W`+1.
- `BCLK_DIV`, 4: `clk` cycles per BCLK period; must be even and ≥ 2.

Ports:
- `clk`, input, 1: system clock; all logic is rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `s_data`, input, `DATA_W`: sample from the filter.
- `s_valid`, input, 1: `s_data` is valid.
- `s_ready`, output, 1: holding register is empty. Reset value 1.
- `i2s_bclk`, output, 1: bit clock, registered. Reset value 0.
- `i2s_lrclk`, output, 1: word select; 0 = left, 1 = right. Registered. Reset value 0.
- `i2s_sd`, output, 1: serial data, registered. Reset value 0.
- `underrun`, output, 1: one-cycle pulse at a frame start that found the holding register empty. Reset value 0.

## Operation
- **Divider:** `div_cnt` runs 0..`BCLK_DIV`-1 and wraps. Each wrap starts a new bit period.
- **Bit counter:** `bit_cnt` k runs 0..2·`SLOT_W`-1 and wraps. Its wrap to 0 is the frame boundary.
- **Slot layout:** slot bit p = k mod `SLOT_W`.
  - p = 0: delay bit, SD = 0.
  - p = 1..`DATA_W`: SD = frame_reg[`DATA_W`-p], i.e. MSB first.
  - p > `DATA_W`: SD = 0.
  - The left slot (k < `SLOT_W`) and the right slot carry the same frame_reg.
- **LRCLK:** 0 for k in 0..`SLOT_W`-1, 1 otherwise. LRCLK therefore changes one BCLK before each channel's MSB.
- **Handshake:** a transfer occurs on any cycle with `s_valid` && `s_ready`.
  - `s_data` is captured into `hold`, and `hold_full` is set.
  - `s_ready` = !`hold_full`.
  - While `s_ready` is low, `s_data` is ignored. The source must keep `s_valid` and `s_data` stable until the transfer.
- **Frame boundary, hold full:** frame_reg ← `hold` and `hold_full` clears. `s_ready` is high the next cycle.
- **Frame boundary, hold empty:** frame_reg ← 0 (see Configuration) and `underrun` pulses for that one cycle.
- **Simultaneous events:** a transfer on the boundary cycle with `hold` empty still counts as an underrun. The new sample lands in `hold` and plays in the following frame.
- **Reset (at any time, including mid-frame):**
  - All counters clear to 0, frame_reg clears to 0, `hold_full` clears.
  - Outputs take their reset values immediately.
  - The bit period that starts at reset release is bit 0 of frame 0. Frame 0 is silent and never flags underrun.

## Timing
- Each BCLK period is `BCLK_DIV` `clk` cycles:
  - `i2s_bclk` is low for the first `BCLK_DIV`/2 cycles and high for the rest.
  - `i2s_sd` and `i2s_lrclk` update only on the clock edge that starts a period, coincident with the BCLK falling edge.
  - The DAC samples SD on the BCLK rising edge.
- Frame length = 2·`SLOT_W`·`BCLK_DIV` `clk` cycles (256 at the defaults).
- Frame n starts at cycle n·256 after reset release (defaults).
- **Latency:** a sample in `hold` at a boundary shows its left MSB on SD exactly `BCLK_DIV` cycles after that boundary edge.
- Throughput is one sample per frame. A full `hold` blocks the source until the next boundary.

## Configuration
- `FIR_I2S_TX_HOLD_LAST_EN`
  - Defined: on underrun, frame_reg keeps its previous value, so the last sample repeats. `underrun` still pulses.
  - Undefined: on underrun, frame_reg is zeroed (silence).
  - Reset behaviour is the same in both builds.

## Test plan
All scenarios use the defaults: 24/32/4, 256-cycle frame.
- **Reset:** assert `reset_n`=0 mid-frame, then release, with no stimulus.
  - Outputs go to 0 at once and `s_ready`=1.
  - SD stays 0 for all of frame 0 and `underrun` stays 0.
  - `underrun` pulses at cycle 256.
- **Basic transfer:** send 0xA5A5A5 at cycle 10.
  - `s_ready` drops at cycle 11.
  - In frame 1, SD bits k=1..24 and k=33..56 equal 0xA5A5A5, MSB first.
  - All other bits are 0 and `underrun` stays 0.
  - `s_ready` rises one cycle after boundary 256.
- **Backpressure:** send 0x800001, then hold 0x7FFFFF valid.
  - 0x7FFFFF is accepted only after boundary 256.
  - It plays in frame 2 with its MSB (0) at k=1.
- **Boundary collision:** with `hold` empty, assert `s_valid` with 0x123456 exactly on boundary cycle 256.
  - `underrun` pulses and frame 1 is silent.
  - 0x123456 plays in frame 2.
- **Underrun policy:** play 0x0F0F0F, then supply nothing.
  - The next frame is all-zero and `underrun` pulses.
  - With `FIR_I2S_TX_HOLD_LAST_EN` defined, 0x0F0F0F repeats instead.
- **LRCLK timing:** check that LRCLK toggles at k=0 and k=32 only, on BCLK falling edges.
